// File: rtl/generador_tablero.sv
// Pixel renderer for side-by-side battleship boards: cell-state memory with a clear
// sequencer, blinking cursor and a two-stage pixel pipeline (coordinates in, RGB out).
module generador_tablero #(
   parameter int H_RES        = 640,
   parameter int V_RES        = 480,
   parameter int TABLEROS     = 2,
   parameter int FILAS        = 5,
   parameter int COLS         = 5,
   parameter int ANCHO        = 5,
   parameter int BLINK_FRAMES = 30,
   localparam int TW = (TABLEROS > 1) ? $clog2(TABLEROS) : 1,
   localparam int FW = (FILAS > 1) ? $clog2(FILAS) : 1,
   localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [9:0]     x,
   input  logic [9:0]     y,
   input  logic           pix_valid,
   input  logic           frame_start,
   input  logic           clr,
   input  logic           wr_valid,
   output logic           wr_ready,
   input  logic [TW-1:0]  wr_tablero,
   input  logic [FW-1:0]  wr_fila,
   input  logic [CLW-1:0] wr_col,
   input  logic [1:0]     wr_estado,
   input  logic           cursor_en,
   input  logic [TW-1:0]  cursor_tablero,
   input  logic [FW-1:0]  cursor_fila,
   input  logic [CLW-1:0] cursor_col,
   output logic [7:0]     red,
   output logic [7:0]     green,
   output logic [7:0]     blue,
   output logic           rgb_valid
);

   localparam int SW      = H_RES / TABLEROS;
   localparam int CW      = (SW - ANCHO) / COLS;
   localparam int CH      = (V_RES - ANCHO) / FILAS;
   localparam int NCELDAS = TABLEROS * FILAS * COLS;
   localparam int AW      = (NCELDAS > 1) ? $clog2(NCELDAS) : 1;
   localparam int CNTW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   typedef enum logic {CLEAR, IDLE} fsm_t;

   fsm_t            fsm;
   logic [AW-1:0]   clr_idx;
   logic [1:0]      mem [NCELDAS];

   logic [CNTW-1:0] cnt;
   logic            fase;

   logic [31:0]     b_c, xl_c, col_c, row_c;
   logic            fuera_c, linea_c, cursor_c;
   logic [AW-1:0]   addr_c;
   logic [AW-1:0]   wr_addr;
   logic            wr_rango;

   logic            v1, fuera1, linea1, cur1;
   logic [1:0]      estado1;

   always_comb begin
      b_c      = 32'(x) / 32'(SW);
      xl_c     = 32'(x) - b_c * 32'(SW);
      col_c    = xl_c / 32'(CW);
      row_c    = 32'(y) / 32'(CH);
      fuera_c  = (b_c >= 32'(TABLEROS)) || (col_c >= 32'(COLS)) || (row_c >= 32'(FILAS));
      linea_c  = ((xl_c % 32'(CW)) < 32'(ANCHO)) || ((32'(y) % 32'(CH)) < 32'(ANCHO));
      addr_c   = AW'((b_c * 32'(FILAS) + row_c) * 32'(COLS) + col_c);
      cursor_c = cursor_en && fase && (b_c == 32'(cursor_tablero)) &&
                 (row_c == 32'(cursor_fila)) && (col_c == 32'(cursor_col));
      wr_rango = (32'(wr_tablero) < 32'(TABLEROS)) && (32'(wr_fila) < 32'(FILAS)) &&
                 (32'(wr_col) < 32'(COLS));
      wr_addr  = AW'((32'(wr_tablero) * 32'(FILAS) + 32'(wr_fila)) * 32'(COLS) + 32'(wr_col));
   end

   // Clear sequencer: one entry per cycle; clr at any time restarts from entry 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm      <= CLEAR;
         clr_idx  <= '0;
         wr_ready <= 1'b0;
      end else begin
         case (fsm)
            CLEAR: begin
               if (clr) begin
                  clr_idx <= '0;
               end else if (clr_idx == AW'(NCELDAS - 1)) begin
                  fsm      <= IDLE;
                  wr_ready <= 1'b1;
                  clr_idx  <= '0;
               end else begin
                  clr_idx <= clr_idx + AW'(1);
               end
            end
            default: begin
               if (clr) begin
                  fsm      <= CLEAR;
                  wr_ready <= 1'b0;
                  clr_idx  <= '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (fsm == CLEAR) begin
         mem[clr_idx] <= 2'd0;
      end else if (wr_valid && wr_ready && wr_rango) begin
         mem[wr_addr] <= wr_estado;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         fase <= 1'b1;
      end else if (frame_start) begin
         if (cnt == CNTW'(BLINK_FRAMES - 1)) begin
            cnt  <= '0;
            fase <= ~fase;
         end else begin
            cnt <= cnt + CNTW'(1);
         end
      end
   end

   // Stage 1 reads the memory before any same-cycle write lands, so pixels see the old state.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1      <= 1'b0;
         fuera1  <= 1'b0;
         linea1  <= 1'b0;
         cur1    <= 1'b0;
         estado1 <= 2'd0;
      end else begin
         v1      <= pix_valid;
         fuera1  <= fuera_c;
         linea1  <= linea_c;
         cur1    <= cursor_c;
         estado1 <= fuera_c ? 2'd0 : mem[addr_c];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !v1) begin
         rgb_valid <= 1'b0;
         red       <= 8'h00;
         green     <= 8'h00;
         blue      <= 8'h00;
      end else begin
         rgb_valid <= 1'b1;
         if (fuera1 || linea1) begin
            {red, green, blue} <= 24'h000000;
         end else if (cur1) begin
            {red, green, blue} <= 24'hFFFFFF;
         end else begin
            case (estado1)
               2'd0:    {red, green, blue} <= 24'h0000FF;
               2'd1:    {red, green, blue} <= 24'hFF0000;
               2'd2:    {red, green, blue} <= 24'h00FF00;
               default: {red, green, blue} <= 24'h808080;
            endcase
         end
      end
   end

endmodule
